dispatch_router: RTL and testbench

//  Registered, back-pressured dispatch stage between decode/rename and the issue

---
 rtl/dispatch_pkg.sv | 62 ++++++
 rtl/dispatch_fifo_entry.sv | 53 +++++
 rtl/dispatch_router.sv | 159 +++++++++++++++
 tb/tb_dispatch_router.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// Shared types, opcodes and classification for the dispatch stage.
package dispatch_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned TAG_W     = 6;
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned NQ        = 4;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;

  // Encodings 0..3 double as the issue-queue index.
  typedef enum logic [2:0] {
    ClsInt  = 3'd0,
    ClsLdst = 3'd1,
    ClsMult = 3'd2,
    ClsDiv  = 3'd3,
    ClsNone = 3'd4
  } disp_cls_e;

  // Operand vt fields are {pending, tag}; pending=1 means the value is not yet available.
  typedef struct packed {
    logic [TAG_W:0]   rs1_vt;
    logic [XLEN-1:0]  rs1_data;
    logic [TAG_W:0]   rs2_vt;
    logic [XLEN-1:0]  rs2_data;
    logic [TAG_W-1:0] rd_tag;
  } queue_data_t;

  typedef struct packed {
    queue_data_t     data;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;
    logic            is_store;
  } disp_pkt_t;

  function automatic disp_cls_e classify(input logic [6:0] opcode, input logic [2:0] func3,
                                         input logic [6:0] func7);
    disp_cls_e cls;
    case (opcode)
      OpReg: begin
        if (func7 == 7'd1 && func3 == 3'd4)      cls = ClsDiv;
        else if (func7 == 7'd1 && func3 == 3'd0) cls = ClsMult;
        else                                     cls = ClsInt;
      end
      OpImm, OpLui, OpJalr, OpBranch, OpAuipc: cls = ClsInt;
      OpLoad, OpStore:                         cls = ClsLdst;
      default:                                 cls = ClsNone;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/dispatch_fifo_entry.sv
// One dispatch buffer slot: holds a packet and wakes pending operands from the CDB.
module dispatch_fifo_entry
  import dispatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  disp_pkt_t        wr_pkt,
  input  disp_cls_e        wr_cls,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output disp_pkt_t        pkt,
  output disp_cls_e        cls
);

  disp_pkt_t pkt_q, pkt_d;
  disp_cls_e cls_q, cls_d;

  // Write wins over wakeup: the write packet already carries same-cycle CDB results.
  always_comb begin
    pkt_d = pkt_q;
    cls_d = cls_q;
    if (wr_en) begin
      pkt_d = wr_pkt;
      cls_d = wr_cls;
    end else if (cdb_valid) begin
      if (pkt_q.data.rs1_vt[TAG_W] && pkt_q.data.rs1_vt[TAG_W-1:0] == cdb_tag) begin
        pkt_d.data.rs1_vt[TAG_W] = 1'b0;
        pkt_d.data.rs1_data      = cdb_data;
      end
      if (pkt_q.data.rs2_vt[TAG_W] && pkt_q.data.rs2_vt[TAG_W-1:0] == cdb_tag) begin
        pkt_d.data.rs2_vt[TAG_W] = 1'b0;
        pkt_d.data.rs2_data      = cdb_data;
      end
    end
  end

  // Slot storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q <= '0;
      cls_q <= ClsInt;
    end else begin
      pkt_q <= pkt_d;
      cls_q <= cls_d;
    end
  end

  assign pkt = pkt_q;
  assign cls = cls_q;

endmodule

// File: rtl/dispatch_router.sv
// Buffered dispatch stage: classifies, packages and queues instructions toward issue queues.
module dispatch_router
  import dispatch_pkg::*;
#(
  parameter int unsigned BufDepth = BUF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [4:0]                  in_rs1_idx,
  input  logic [4:0]                  in_rs2_idx,
  input  logic [XLEN-1:0]             in_rs1_data,
  input  logic [XLEN-1:0]             in_rs2_data,
  input  logic                        in_rs1_fwd,
  input  logic                        in_rs2_fwd,
  input  logic [TAG_W:0]              in_rs1_vt,
  input  logic [TAG_W:0]              in_rs2_vt,
  input  logic [6:0]                  in_opcode,
  input  logic [2:0]                  in_func3,
  input  logic [6:0]                  in_func7,
  input  logic [XLEN-1:0]             in_imm,
  input  logic [TAG_W-1:0]            in_rd_tag,
  input  logic                        cdb_valid,
  input  logic [TAG_W-1:0]            cdb_tag,
  input  logic [XLEN-1:0]             cdb_data,
  output logic [NQ-1:0]               out_valid,
  input  logic [NQ-1:0]               out_ready,
  output disp_pkt_t                   out_pkt,
  output logic [$clog2(BufDepth):0]   buf_count
);

  localparam int unsigned PtrW = $clog2(BufDepth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full, empty, wr_en, pop;
  logic            rs1_valid, rs2_valid;
  logic [XLEN-1:0] rs1_data, rs2_data;
  disp_cls_e       cls_in, head_cls;
  disp_pkt_t       pkt_in, head_pkt;
  disp_pkt_t       ent_pkt [BufDepth];
  disp_cls_e       ent_cls [BufDepth];

  assign full     = (count_q == CntW'(BufDepth));
  assign empty    = (count_q == '0);
  assign in_ready = ~full;

  // Build the reservation packet for the incoming instruction.
  always_comb begin
    cls_in    = classify(in_opcode, in_func3, in_func7);
    rs1_valid = (in_rs1_idx == 5'd0) || in_rs1_fwd || !in_rs1_vt[TAG_W];
    rs1_data  = (in_rs1_idx == 5'd0) ? '0 : in_rs1_data;
    rs2_valid = (in_rs2_idx == 5'd0) || in_rs2_fwd || !in_rs2_vt[TAG_W];
    rs2_data  = (in_rs2_idx == 5'd0) ? '0 : in_rs2_data;
    if (in_opcode == OpImm || in_opcode == OpLui) begin
      rs2_valid = 1'b1;
      rs2_data  = in_imm;
    end else if (in_opcode == OpLoad) begin
      rs2_valid = 1'b1;
    end
    // Catch a producer broadcasting in the very cycle we enqueue.
    if (!rs1_valid && cdb_valid && cdb_tag == in_rs1_vt[TAG_W-1:0]) begin
      rs1_valid = 1'b1;
      rs1_data  = cdb_data;
    end
    if (!rs2_valid && cdb_valid && cdb_tag == in_rs2_vt[TAG_W-1:0]) begin
      rs2_valid = 1'b1;
      rs2_data  = cdb_data;
    end
    pkt_in               = '0;
    pkt_in.data.rs1_vt   = {!rs1_valid, in_rs1_vt[TAG_W-1:0]};
    pkt_in.data.rs1_data = rs1_data;
    pkt_in.data.rs2_vt   = {!rs2_valid, in_rs2_vt[TAG_W-1:0]};
    pkt_in.data.rs2_data = rs2_data;
    pkt_in.data.rd_tag   = in_rd_tag;
    pkt_in.opcode        = in_opcode;
    pkt_in.func3         = in_func3;
    pkt_in.func7         = in_func7;
    pkt_in.imm           = in_imm;
    pkt_in.is_store      = (in_opcode == OpStore);
  end

  // Unclassifiable instructions are accepted but never written.
  assign wr_en = in_valid && in_ready && !flush && (cls_in != ClsNone);

  for (genvar g = 0; g < BufDepth; g++) begin : g_entry
    dispatch_fifo_entry u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en && (wr_ptr_q == PtrW'(g))),
      .wr_pkt    (pkt_in),
      .wr_cls    (cls_in),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .pkt       (ent_pkt[g]),
      .cls       (ent_cls[g])
    );
  end

  assign head_pkt = ent_pkt[rd_ptr_q];
  assign head_cls = ent_cls[rd_ptr_q];
  assign out_pkt  = empty ? '0 : head_pkt;

  // One-hot request to the head entry's target queue.
  always_comb begin
    out_valid = '0;
    if (!empty) begin
      case (head_cls)
        ClsInt:  out_valid[0] = 1'b1;
        ClsLdst: out_valid[1] = 1'b1;
        ClsMult: out_valid[2] = 1'b1;
        ClsDiv:  out_valid[3] = 1'b1;
        default: out_valid    = '0;
      endcase
    end
  end

  assign pop = !empty && ((out_valid & out_ready) != '0) && !flush;

  // Pointer and occupancy next-state; flush overrides both push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign buf_count = count_q;

endmodule

// File: tb/tb_dispatch_router.sv
// Self-checking bench for dispatch_router: vector table plus scoreboard-checked output.
module tb_dispatch_router;
  import dispatch_pkg::*;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready;
  logic [4:0] in_rs1_idx, in_rs2_idx;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm, cdb_data;
  logic in_rs1_fwd, in_rs2_fwd, cdb_valid;
  logic [TAG_W:0] in_rs1_vt, in_rs2_vt;
  logic [6:0] in_opcode, in_func7;
  logic [2:0] in_func3;
  logic [TAG_W-1:0] in_rd_tag, cdb_tag;
  logic [NQ-1:0] out_valid, out_ready;
  disp_pkt_t out_pkt;
  logic [$clog2(BUF_DEPTH):0] buf_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dispatch_router dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .in_rs1_fwd(in_rs1_fwd), .in_rs2_fwd(in_rs2_fwd),
    .in_rs1_vt(in_rs1_vt), .in_rs2_vt(in_rs2_vt), .in_opcode(in_opcode), .in_func3(in_func3),
    .in_func7(in_func7), .in_imm(in_imm), .in_rd_tag(in_rd_tag), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pkt(out_pkt), .buf_count(buf_count)
  );

  typedef struct {
    logic [3:0] ov; logic rs1_p; logic [31:0] rs1_d; logic rs2_p; logic [31:0] rs2_d;
    logic [5:0] rd; logic [6:0] op; logic [31:0] imm; logic st;
  } exp_t;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    logic [4:0] i1; logic [31:0] d1; logic fw1; logic [6:0] vt1;
    logic [4:0] i2; logic [31:0] d2; logic fw2; logic [6:0] vt2;
    logic [31:0] imm; logic [5:0] rd; logic cv; logic [5:0] ct; logic [31:0] cd;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  exp_t got;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mkexp(input logic [3:0] ov, input logic p1, input logic [31:0] d1,
                                 input logic p2, input logic [31:0] d2, input logic [5:0] rd,
                                 input logic [6:0] op, input logic [31:0] imm, input logic st);
    exp_t e;
    e.ov = ov; e.rs1_p = p1; e.rs1_d = d1; e.rs2_p = p2; e.rs2_d = d2;
    e.rd = rd; e.op = op; e.imm = imm; e.st = st;
    return e;
  endfunction

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] i1, input logic [31:0] d1, input logic fw1,
                              input logic [6:0] vt1, input logic [4:0] i2, input logic [31:0] d2,
                              input logic fw2, input logic [6:0] vt2, input logic [31:0] imm,
                              input logic [5:0] rd, input logic cv, input logic [5:0] ct,
                              input logic [31:0] cd, input logic [3:0] ov, input logic p1,
                              input logic [31:0] e1, input logic p2, input logic [31:0] e2,
                              input logic st);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.i1 = i1; v.d1 = d1; v.fw1 = fw1; v.vt1 = vt1;
    v.i2 = i2; v.d2 = d2; v.fw2 = fw2; v.vt2 = vt2; v.imm = imm; v.rd = rd;
    v.cv = cv; v.ct = ct; v.cd = cd;
    v.e = mkexp(ov, p1, e1, p2, e2, rd, op, imm, st);
    return v;
  endfunction

  // Scoreboard: compare the head packet whenever a queue accepts it this cycle.
  always @(negedge clk) begin
    if (rst_n && !flush && ((out_valid & out_ready) != '0)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: out_valid=%b with no expected entry", out_valid);
      end else begin
        got = sb.pop_front();
        chk("sb_out_valid", 64'(out_valid), 64'(got.ov));
        chk("sb_rs1_pending", 64'(out_pkt.data.rs1_vt[TAG_W]), 64'(got.rs1_p));
        if (!got.rs1_p) chk("sb_rs1_data", 64'(out_pkt.data.rs1_data), 64'(got.rs1_d));
        chk("sb_rs2_pending", 64'(out_pkt.data.rs2_vt[TAG_W]), 64'(got.rs2_p));
        if (!got.rs2_p) chk("sb_rs2_data", 64'(out_pkt.data.rs2_data), 64'(got.rs2_d));
        chk("sb_rd_tag", 64'(out_pkt.data.rd_tag), 64'(got.rd));
        chk("sb_opcode", 64'(out_pkt.opcode), 64'(got.op));
        chk("sb_imm", 64'(out_pkt.imm), 64'(got.imm));
        chk("sb_is_store", 64'(out_pkt.is_store), 64'(got.st));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Simple instruction: rs1=x1, rs2=x2, data derived from rd, no forwarding, imm 0.
  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [5:0] rd, input logic [6:0] vt1, input logic [6:0] vt2);
    in_opcode = op; in_func3 = f3; in_func7 = f7; in_rd_tag = rd;
    in_rs1_idx = 5'd1; in_rs2_idx = 5'd2;
    in_rs1_data = 32'h1000 + 32'(rd); in_rs2_data = 32'h2000 + 32'(rd);
    in_rs1_fwd = 1'b0; in_rs2_fwd = 1'b0; in_rs1_vt = vt1; in_rs2_vt = vt2; in_imm = '0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = '0; cdb_valid = 1'b0;
    cdb_tag = '0; cdb_data = '0;
    set_instr(7'h33, 3'd0, 7'd0, 6'd0, 7'h00, 7'h00);

    //          op     f3    f7     i1  d1            fw vt1    i2  d2            fw vt2
    //          imm            rd  cv ct  cd            ov       p1 e1            p2 e2 st
    tbl[0]  = mk(7'h33, 3'd0, 7'h00, 5'd1, 32'h11, 0, 7'h45, 5'd2, 32'h22, 0, 7'h46,
                 32'h0, 6'd3, 0, 6'd0, 32'h0, 4'b0001, 1, 32'h0, 1, 32'h0, 0);
    tbl[1]  = mk(7'h33, 3'd0, 7'h20, 5'd1, 32'hA, 0, 7'h01, 5'd2, 32'hB, 1, 7'h42,
                 32'h0, 6'd4, 0, 6'd0, 32'h0, 4'b0001, 0, 32'hA, 0, 32'hB, 0);
    tbl[2]  = mk(7'h33, 3'd0, 7'h01, 5'd5, 32'h5, 0, 7'h05, 5'd6, 32'h6, 0, 7'h06,
                 32'h0, 6'd5, 0, 6'd0, 32'h0, 4'b0100, 0, 32'h5, 0, 32'h6, 0);
    tbl[3]  = mk(7'h33, 3'd4, 7'h01, 5'd5, 32'h5, 0, 7'h05, 5'd6, 32'h6, 0, 7'h06,
                 32'h0, 6'd6, 0, 6'd0, 32'h0, 4'b1000, 0, 32'h5, 0, 32'h6, 0);
    tbl[4]  = mk(7'h33, 3'd5, 7'h01, 5'd5, 32'h5, 0, 7'h05, 5'd6, 32'h6, 0, 7'h06,
                 32'h0, 6'd7, 0, 6'd0, 32'h0, 4'b0001, 0, 32'h5, 0, 32'h6, 0);
    tbl[5]  = mk(7'h13, 3'd0, 7'h00, 5'd0, 32'h1234, 0, 7'h47, 5'd5, 32'h55, 0, 7'h49,
                 32'hFFFF_FFFC, 6'd8, 0, 6'd0, 32'h0, 4'b0001, 0, 32'h0, 0, 32'hFFFF_FFFC, 0);
    tbl[6]  = mk(7'h37, 3'd0, 7'h00, 5'd0, 32'h99, 0, 7'h48, 5'd0, 32'h77, 0, 7'h4A,
                 32'h1234_5000, 6'd9, 0, 6'd0, 32'h0, 4'b0001, 0, 32'h0, 0, 32'h1234_5000, 0);
    tbl[7]  = mk(7'h03, 3'd2, 7'h00, 5'd4, 32'h40, 0, 7'h4A, 5'd7, 32'h77, 0, 7'h4B,
                 32'h8, 6'd10, 0, 6'd0, 32'h0, 4'b0010, 1, 32'h0, 0, 32'h77, 0);
    tbl[8]  = mk(7'h23, 3'd2, 7'h00, 5'd2, 32'h200, 0, 7'h03, 5'd3, 32'h33, 0, 7'h4E,
                 32'h4, 6'd11, 0, 6'd0, 32'h0, 4'b0010, 0, 32'h200, 1, 32'h0, 1);
    tbl[9]  = mk(7'h63, 3'd0, 7'h00, 5'd1, 32'h1, 1, 7'h4F, 5'd2, 32'h2, 0, 7'h02,
                 32'h10, 6'd12, 0, 6'd0, 32'h0, 4'b0001, 0, 32'h1, 0, 32'h2, 0);
    tbl[10] = mk(7'h67, 3'd0, 7'h00, 5'd1, 32'h1000, 0, 7'h01, 5'd0, 32'h5, 0, 7'h50,
                 32'h0, 6'd13, 0, 6'd0, 32'h0, 4'b0001, 0, 32'h1000, 0, 32'h0, 0);
    tbl[11] = mk(7'h17, 3'd0, 7'h00, 5'd0, 32'h3, 0, 7'h00, 5'd0, 32'h4, 0, 7'h00,
                 32'h2000, 6'd14, 0, 6'd0, 32'h0, 4'b0001, 0, 32'h0, 0, 32'h0, 0);
    tbl[12] = mk(7'h6F, 3'd0, 7'h00, 5'd0, 32'h0, 0, 7'h00, 5'd0, 32'h0, 0, 7'h00,
                 32'h40, 6'd15, 0, 6'd0, 32'h0, 4'b0000, 0, 32'h0, 0, 32'h0, 0);
    tbl[13] = mk(7'h7F, 3'd0, 7'h00, 5'd0, 32'h0, 0, 7'h00, 5'd0, 32'h0, 0, 7'h00,
                 32'h0, 6'd16, 0, 6'd0, 32'h0, 4'b0000, 0, 32'h0, 0, 32'h0, 0);
    tbl[14] = mk(7'h33, 3'd0, 7'h00, 5'd8, 32'h8, 0, 7'h4C, 5'd9, 32'h9, 0, 7'h4D,
                 32'h0, 6'd17, 1, 6'd12, 32'hCAFE, 4'b0001, 0, 32'hCAFE, 1, 32'h0, 0);
    tbl[15] = mk(7'h33, 3'd0, 7'h00, 5'd8, 32'h8, 0, 7'h4D, 5'd9, 32'h9, 0, 7'h4C,
                 32'h0, 6'd18, 1, 6'd12, 32'hBEEF, 4'b0001, 1, 32'h0, 0, 32'hBEEF, 0);

    // Reset state, before any clock edge.
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_buf_count", 64'(buf_count), 64'(0));
    chk("rst_out_pkt_zero", 64'(out_pkt != '0), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Table: one instruction per cycle with all queues ready (sustained throughput).
    out_ready = 4'hF;
    for (int i = 0; i < 16; i++) begin
      in_opcode = tbl[i].op; in_func3 = tbl[i].f3; in_func7 = tbl[i].f7;
      in_rs1_idx = tbl[i].i1; in_rs1_data = tbl[i].d1; in_rs1_fwd = tbl[i].fw1;
      in_rs1_vt = tbl[i].vt1; in_rs2_idx = tbl[i].i2; in_rs2_data = tbl[i].d2;
      in_rs2_fwd = tbl[i].fw2; in_rs2_vt = tbl[i].vt2; in_imm = tbl[i].imm;
      in_rd_tag = tbl[i].rd; cdb_valid = tbl[i].cv; cdb_tag = tbl[i].ct; cdb_data = tbl[i].cd;
      in_valid = 1'b1;
      chk("tbl_in_ready", 64'(in_ready), 64'(1));
      if (tbl[i].e.ov != 4'b0000) sb.push_back(tbl[i].e);
      tick();
    end
    in_valid = 1'b0; cdb_valid = 1'b0;
    repeat (3) tick();
    chk("tbl_drained", 64'(buf_count), 64'(0));
    out_ready = '0;

    // Pending ADD held without ready, then rs1 woken by CDB tag 5.
    set_instr(7'h33, 3'd0, 7'd0, 6'd3, 7'h45, 7'h46);
    in_valid = 1'b1;
    sb.push_back(mkexp(4'b0001, 0, 32'hDEAD, 1, 32'h0, 6'd3, 7'h33, 32'h0, 0));
    tick();
    in_valid = 1'b0;
    chk("hold_out_valid", 64'(out_valid), 64'(4'b0001));
    chk("hold_rs1_pending", 64'(out_pkt.data.rs1_vt[TAG_W]), 64'(1));
    tick();
    chk("hold_out_valid_2", 64'(out_valid), 64'(4'b0001));
    chk("hold_rd_tag", 64'(out_pkt.data.rd_tag), 64'(3));
    chk("hold_rs2_pending", 64'(out_pkt.data.rs2_vt[TAG_W]), 64'(1));
    cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'hDEAD;
    tick();
    cdb_valid = 1'b0;
    chk("wake_rs1_pending", 64'(out_pkt.data.rs1_vt[TAG_W]), 64'(0));
    chk("wake_rs1_data", 64'(out_pkt.data.rs1_data), 64'(32'hDEAD));
    chk("wake_rs2_pending", 64'(out_pkt.data.rs2_vt[TAG_W]), 64'(1));
    chk("wake_count", 64'(buf_count), 64'(1));
    out_ready = 4'hF;
    tick();
    out_ready = '0;
    chk("wake_drained", 64'(buf_count), 64'(0));

    // Two loads fill the buffer; a pop in the full cycle does not admit a third.
    set_instr(7'h03, 3'd2, 7'd0, 6'd7, 7'h01, 7'h41);
    in_valid = 1'b1;
    sb.push_back(mkexp(4'b0010, 0, 32'h1007, 0, 32'h2007, 6'd7, 7'h03, 32'h0, 0));
    tick();
    set_instr(7'h03, 3'd2, 7'd0, 6'd8, 7'h01, 7'h41);
    sb.push_back(mkexp(4'b0010, 0, 32'h1008, 0, 32'h2008, 6'd8, 7'h03, 32'h0, 0));
    tick();
    set_instr(7'h03, 3'd2, 7'd0, 6'd9, 7'h01, 7'h41);
    chk("full_count", 64'(buf_count), 64'(2));
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("full_out_valid", 64'(out_valid), 64'(4'b0010));
    tick();
    chk("full_count_hold", 64'(buf_count), 64'(2));
    out_ready = 4'hF;
    chk("full_ready_pop_cycle", 64'(in_ready), 64'(0));
    tick();
    in_valid = 1'b0;
    chk("drain_count_1", 64'(buf_count), 64'(1));
    chk("drain_in_ready", 64'(in_ready), 64'(1));
    tick();
    chk("drain_count_0", 64'(buf_count), 64'(0));
    out_ready = '0;

    // MUL then DIV route to queues 2 and 3; a ready on the wrong queue does not pop.
    set_instr(7'h33, 3'd0, 7'd1, 6'd20, 7'h01, 7'h02);
    in_valid = 1'b1;
    sb.push_back(mkexp(4'b0100, 0, 32'h1014, 0, 32'h2014, 6'd20, 7'h33, 32'h0, 0));
    tick();
    set_instr(7'h33, 3'd4, 7'd1, 6'd21, 7'h01, 7'h02);
    sb.push_back(mkexp(4'b1000, 0, 32'h1015, 0, 32'h2015, 6'd21, 7'h33, 32'h0, 0));
    tick();
    in_valid = 1'b0;
    chk("mul_out_valid", 64'(out_valid), 64'(4'b0100));
    out_ready = 4'b1011;
    tick();
    chk("wrong_ready_count", 64'(buf_count), 64'(2));
    chk("wrong_ready_out_valid", 64'(out_valid), 64'(4'b0100));
    out_ready = 4'b0100;
    tick();
    chk("div_out_valid", 64'(out_valid), 64'(4'b1000));
    out_ready = 4'b1000;
    tick();
    out_ready = '0;
    chk("muldiv_drained", 64'(buf_count), 64'(0));

    // Flush while full with enqueue and pop requested: both ignored, buffer empties.
    set_instr(7'h33, 3'd0, 7'd0, 6'd30, 7'h01, 7'h02);
    in_valid = 1'b1;
    sb.push_back(mkexp(4'b0001, 0, 32'h101E, 0, 32'h201E, 6'd30, 7'h33, 32'h0, 0));
    tick();
    set_instr(7'h33, 3'd0, 7'd0, 6'd31, 7'h01, 7'h02);
    sb.push_back(mkexp(4'b0001, 0, 32'h101F, 0, 32'h201F, 6'd31, 7'h33, 32'h0, 0));
    tick();
    set_instr(7'h33, 3'd0, 7'd0, 6'd32, 7'h01, 7'h02);
    flush = 1'b1; out_ready = 4'hF;
    tick();
    sb.delete();
    chk("flush_count", 64'(buf_count), 64'(0));
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    tick();
    flush = 1'b0;
    chk("flush_enq_ignored", 64'(buf_count), 64'(0));
    set_instr(7'h33, 3'd0, 7'd0, 6'd33, 7'h01, 7'h02);
    sb.push_back(mkexp(4'b0001, 0, 32'h1021, 0, 32'h2021, 6'd33, 7'h33, 32'h0, 0));
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_flush_drained", 64'(buf_count), 64'(0));
    out_ready = '0;

    // Asynchronous reset in the middle of a drain, checked before any clock edge.
    set_instr(7'h33, 3'd0, 7'd0, 6'd40, 7'h01, 7'h02);
    in_valid = 1'b1;
    sb.push_back(mkexp(4'b0001, 0, 32'h1028, 0, 32'h2028, 6'd40, 7'h33, 32'h0, 0));
    tick();
    set_instr(7'h33, 3'd0, 7'd0, 6'd41, 7'h01, 7'h02);
    sb.push_back(mkexp(4'b0001, 0, 32'h1029, 0, 32'h2029, 6'd41, 7'h33, 32'h0, 0));
    tick();
    in_valid = 1'b0;
    out_ready = 4'hF;
    tick();
    chk("pre_reset_count", 64'(buf_count), 64'(1));
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("areset_count", 64'(buf_count), 64'(0));
    chk("areset_out_valid", 64'(out_valid), 64'(0));
    chk("areset_in_ready", 64'(in_ready), 64'(1));
    chk("areset_out_pkt_zero", 64'(out_pkt != '0), 64'(0));
    out_ready = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    chk("sb_all_consumed", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
